// File: rtl/console_pkg.sv
// Shared constants, state encoding and ring-address helper for the text console writer.
package console_pkg;

  localparam int COLS     = 80;
  localparam int ROWS     = 25;
  localparam int BUF_SIZE = 2000;

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] FF    = 8'h0C;

  localparam logic [10:0] BUF_LAST      = 11'(BUF_SIZE - 1);
  localparam logic [10:0] ROW_STRIDE    = 11'(COLS);
  localparam logic [10:0] LAST_ROW_BASE = 11'(BUF_SIZE - COLS);
  localparam logic [10:0] LINE_LAST     = 11'(COLS - 1);
  localparam logic [6:0]  COL_LAST      = 7'(COLS - 1);
  localparam logic [4:0]  ROW_LAST      = 5'(ROWS - 1);

  typedef enum logic [1:0] {
    INIT_CLEAR = 2'd0,
    IDLE       = 2'd1,
    WRITE      = 2'd2,
    CLEAR_LINE = 2'd3
  } state_e;

  // Step a row base address forward by one row around the 2000-cell ring.
  function automatic logic [10:0] next_row(input logic [10:0] base);
    return (base == LAST_ROW_BASE) ? 11'd0 : base + ROW_STRIDE;
  endfunction

endpackage

// File: rtl/cursor_blink.sv
// Free-running cursor blink phase; restart forces the visible phase and restarts the count.
module cursor_blink #(
  parameter int unsigned BLINK_HALF = 32'd12000000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic blink_on
);

  logic [31:0] cnt_q, cnt_d;
  logic        blink_q, blink_d;

  always_comb begin
    cnt_d   = cnt_q + 32'd1;
    blink_d = blink_q;
    if (restart) begin
      cnt_d   = 32'd0;
      blink_d = 1'b1;
    end else if (cnt_q >= BLINK_HALF - 32'd1) begin
      cnt_d   = 32'd0;
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= 32'd0;
      blink_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink_on = blink_q;

endmodule

// File: rtl/char_buffer_writer.sv
// Byte-stream to 25x80 ring character buffer writer with scrolling, line clear and full clear.
module char_buffer_writer
  import console_pkg::*;
#(
  parameter int unsigned BLINK_HALF = 32'd12000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [10:0] char_buffer_waddr,
  output logic [7:0]  char_buffer_wdata,
  output logic        char_buffer_we,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic [10:0] first_char,
  output logic        cursor_blink_on
);

  state_e      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [6:0]  x_q, x_d;
  logic [4:0]  y_q, y_d;
  logic [10:0] fc_q, fc_d;
  logic [10:0] lb_q, lb_d;   // ring address of the cursor row's first cell
  logic [7:0]  byte_q, byte_d;
  logic        accept;
  logic        line_feed;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT_CLEAR;
      cnt_q   <= 11'd0;
      x_q     <= 7'd0;
      y_q     <= 5'd0;
      fc_q    <= 11'd0;
      lb_q    <= 11'd0;
      byte_q  <= SPACE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fc_q    <= fc_d;
      lb_q    <= lb_d;
      byte_q  <= byte_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    fc_d      = fc_q;
    lb_d      = lb_q;
    byte_d    = byte_q;
    line_feed = 1'b0;
    case (state_q)
      INIT_CLEAR: begin
        if (cnt_q == BUF_LAST) begin
          cnt_d   = 11'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      IDLE: begin
        if (!accept) begin
          state_d = IDLE;
        end else if (in_data >= 8'h20 && in_data <= 8'h7E) begin
          byte_d  = in_data;
          state_d = WRITE;
        end else begin
          case (in_data)
            CR: x_d = 7'd0;
            LF: line_feed = 1'b1;
            BS: x_d = (x_q != 7'd0) ? x_q - 7'd1 : x_q;
            FF: begin
              fc_d    = 11'd0;
              x_d     = 7'd0;
              y_d     = 5'd0;
              lb_d    = 11'd0;
              cnt_d   = 11'd0;
              state_d = INIT_CLEAR;
            end
            default: state_d = IDLE;
          endcase
        end
      end
      WRITE: begin
        state_d = IDLE;
        if (x_q == COL_LAST) begin
          x_d       = 7'd0;
          line_feed = 1'b1;
        end else begin
          x_d = x_q + 7'd1;
        end
      end
      CLEAR_LINE: begin
        if (cnt_q == LINE_LAST) begin
          cnt_d   = 11'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      default: state_d = INIT_CLEAR;
    endcase
    // A line feed on the bottom row scrolls the window and blanks the new bottom row.
    if (line_feed) begin
      lb_d = next_row(lb_q);
      if (y_q == ROW_LAST) begin
        fc_d    = next_row(fc_q);
        cnt_d   = 11'd0;
        state_d = CLEAR_LINE;
      end else begin
        y_d = y_q + 5'd1;
      end
    end
  end

  always_comb begin
    in_ready          = 1'b0;
    char_buffer_we    = 1'b0;
    char_buffer_waddr = cnt_q;
    char_buffer_wdata = SPACE;
    case (state_q)
      INIT_CLEAR: char_buffer_we = !reset;
      IDLE:       in_ready = !reset;
      WRITE: begin
        char_buffer_we    = !reset;
        char_buffer_waddr = lb_q + {4'd0, x_q};
        char_buffer_wdata = byte_q;
      end
      CLEAR_LINE: begin
        char_buffer_we    = !reset;
        char_buffer_waddr = lb_q + cnt_q;
      end
      default: in_ready = 1'b0;
    endcase
  end

  assign cursor_x   = x_q;
  assign cursor_y   = y_q;
  assign first_char = fc_q;

  cursor_blink #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .clk      (clk),
    .reset    (reset),
    .restart  (accept),
    .blink_on (cursor_blink_on)
  );

endmodule

// File: tb/tb_char_buffer_writer.sv
// Directed and random byte streams checked against a screen-level model of the console writer.
module tb_char_buffer_writer;

  localparam int HALF = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] char_buffer_waddr;
  logic [7:0]  char_buffer_wdata;
  logic        char_buffer_we;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic [10:0] first_char;
  logic        cursor_blink_on;

  char_buffer_writer #(.BLINK_HALF(HALF)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_data           (in_data),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .char_buffer_waddr (char_buffer_waddr),
    .char_buffer_wdata (char_buffer_wdata),
    .char_buffer_we    (char_buffer_we),
    .cursor_x          (cursor_x),
    .cursor_y          (cursor_y),
    .first_char        (first_char),
    .cursor_blink_on   (cursor_blink_on)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rst_cyc = 0;
  int m_fc, m_x, m_y;
  int first_waddr, last_nwr;
  logic [18:0] exp_q[$];
  logic [18:0] wlog[$];

  always @(negedge clk) begin
    if (char_buffer_we === 1'b1) wlog.push_back({char_buffer_waddr, char_buffer_wdata});
  end

  // Edge counter and the edge of the most recent blink restart (reset or accepted byte).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset === 1'b1 || (in_valid === 1'b1 && in_ready === 1'b1)) rst_cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic exp_blink();
    return (((cyc - rst_cyc) / HALF) % 2) == 0;
  endfunction

  task automatic m_clear_all();
    for (int i = 0; i < 2000; i++) exp_q.push_back({11'(i), 8'h20});
    m_fc = 0; m_x = 0; m_y = 0;
  endtask

  task automatic m_linefeed();
    int base;
    if (m_y < 24) begin
      m_y++;
    end else begin
      m_fc = (m_fc + 80) % 2000;
      base = (m_fc + 24 * 80) % 2000;
      for (int c = 0; c < 80; c++) exp_q.push_back({11'(base + c), 8'h20});
    end
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back({11'((m_fc + m_y * 80 + m_x) % 2000), b});
      m_x++;
      if (m_x == 80) begin
        m_x = 0;
        m_linefeed();
      end
    end else if (b == 8'h0D) m_x = 0;
    else if (b == 8'h0A) m_linefeed();
    else if (b == 8'h08) begin
      if (m_x > 0) m_x--;
    end else if (b == 8'h0C) m_clear_all();
  endtask

  task automatic wait_idle(output int busy);
    busy = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      busy++;
      if (busy > 2100) begin
        check("idle_timeout", in_ready, 1);
        break;
      end
    end
  endtask

  task automatic check_log(input string tag);
    int bad = 0;
    check({tag, "_nwr"}, wlog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= wlog.size() || wlog[i] !== exp_q[i]) bad++;
    check({tag, "_wseq_bad"}, bad, 0);
    first_waddr = (wlog.size() > 0) ? int'(wlog[0][18:8]) : -1;
    last_nwr = wlog.size();
    wlog.delete();
    exp_q.delete();
  endtask

  task automatic check_state(input string tag);
    check({tag, "_x"}, cursor_x, m_x);
    check({tag, "_y"}, cursor_y, m_y);
    check({tag, "_fc"}, first_char, m_fc);
    check({tag, "_blink"}, cursor_blink_on, exp_blink());
  endtask

  task automatic op(input logic [7:0] b, input string tag);
    int busy, n;
    m_byte(b);
    n = exp_q.size();
    in_data = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_idle(busy);
    check({tag, "_busy"}, busy, n);
    check_log(tag);
    check_state(tag);
  endtask

  initial begin
    int busy, bad, r;
    logic [7:0] b;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we", char_buffer_we, 0);
    check("rst_ready", in_ready, 0);
    check("rst_x", cursor_x, 0);
    check("rst_y", cursor_y, 0);
    check("rst_fc", first_char, 0);
    check("rst_blink", cursor_blink_on, 1);

    @(posedge clk);
    #1 reset = 1'b0;
    wlog.delete();
    m_clear_all();
    wait_idle(busy);
    check("init_busy", busy, 2000);
    check_log("init");
    check("init_ready", in_ready, 1);
    check_state("init");

    // 'A' is written one cycle after acceptance at cell 0.
    m_byte(8'h41);
    in_data = 8'h41;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("A_we", char_buffer_we, 1);
    check("A_waddr", char_buffer_waddr, 0);
    check("A_wdata", char_buffer_wdata, 8'h41);
    check("A_ready", in_ready, 0);
    wait_idle(busy);
    check("A_busy", busy, 0);
    check_log("A");
    check("A_x", cursor_x, 1);

    op(8'h0D, "cr0");
    for (int i = 0; i < 3; i++) op(8'h0A, "lf3");
    for (int i = 0; i < 79; i++) op(8'($urandom_range(32, 126)), "fill");
    check("pre_Z_x", cursor_x, 79);
    op(8'h5A, "Z");
    check("Z_addr", first_waddr, 319);
    check("Z_x", cursor_x, 0);
    check("Z_y", cursor_y, 4);

    for (int i = 0; i < 20; i++) op(8'h0A, "lf20");
    op(8'h0D, "cr1");
    for (int i = 0; i < 5; i++) op(8'($urandom_range(32, 126)), "fill5");
    op(8'h0A, "scroll");
    check("scroll_fc", first_char, 80);
    check("scroll_addr0", first_waddr, 0);
    check("scroll_nwr", last_nwr, 80);
    check("scroll_x", cursor_x, 5);
    check("scroll_y", cursor_y, 24);
    op(8'h42, "B");
    check("B_addr", first_waddr, 5);

    for (int i = 0; i < 23; i++) op(8'h0A, "lf23");
    check("fc_1920", first_char, 1920);
    op(8'h0D, "cr2");
    op(8'h0A, "wrap");
    check("wrap_fc", first_char, 0);
    check("wrap_addr0", first_waddr, 1920);
    op(8'h0D, "cr3");
    op(8'h08, "bs0");
    check("bs0_nwr", last_nwr, 0);
    check("bs0_x", cursor_x, 0);
    check("bs0_y", cursor_y, 24);
    op(8'h90, "junk");
    check("junk_nwr", last_nwr, 0);

    bad = 0;
    for (int i = 0; i < 4 * HALF + 3; i++) begin
      @(negedge clk);
      if (cursor_blink_on !== exp_blink()) bad++;
    end
    check("blink_window_bad", bad, 0);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60) b = 8'($urandom_range(32, 126));
      else if (r < 72) b = 8'h0A;
      else if (r < 78) b = 8'h0D;
      else if (r < 86) b = 8'h08;
      else if (r < 99) b = 8'($urandom_range(0, 255));
      else b = 8'h0C;
      op(b, "rnd");
    end

    // Abort a line clear part-way with reset.
    while (m_y < 24) op(8'h0A, "lf_fill");
    in_data = 8'h0A;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    wlog.delete();
    exp_q.delete();
    m_clear_all();
    wait_idle(busy);
    check("abort_busy", busy, 2000);
    check_log("abort");
    check_state("abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
